soc_ram_arbiter: RTL

SOC_RAM_ARBITER -- requirements
Module: soc_ram_arbiter

---
 rtl/soc_ram_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/soc_ram_arbiter.sv
// Two-master arbiter in front of a single-port RAM: master 1 (data) normally wins,
// master 0 (fetch) is forced through after p_max_wait consecutive denials.
module soc_ram_arbiter #(
  parameter logic [31:0] p_addr_base = 32'h1000_0000,
  parameter logic [31:0] p_addr_mask = 32'hffff_f000,
  parameter int unsigned p_max_wait  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  // master 0 (fetch, read-only)
  input  logic        i_m0_req,
  input  logic [31:2] i_m0_addr,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_rdata,
  output logic        o_m0_err,
  // master 1 (data)
  input  logic        i_m1_req,
  input  logic        i_m1_we,
  input  logic [3:0]  i_m1_be,
  input  logic [31:2] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_rdata,
  output logic        o_m1_err,
  // RAM
  output logic [31:2] o_ram_addr,
  output logic [3:0]  o_ram_be,
  output logic        o_ram_wr_en,
  output logic [31:0] o_ram_wr_data,
  output logic        o_ram_rd_en,
  input  logic [31:0] i_ram_rd_data,
  input  logic        i_ram_busy
);

  localparam logic [3:0] c_max_wait = 4'(p_max_wait);

  function automatic logic in_region(input logic [31:2] addr);
    return (addr & p_addr_mask[31:2]) == (p_addr_base[31:2] & p_addr_mask[31:2]);
  endfunction

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       ready_q, ready_d;
  logic       rsp_vld_q, rsp_vld_d;
  logic       rsp_owner_q, rsp_owner_d;
  logic       rsp_err_q, rsp_err_d;
  logic       rsp_rd_q, rsp_rd_d;

  logic        can_grant, force_m0, m0_gnt, m1_gnt, any_gnt;
  logic [31:2] sel_addr;
  logic [3:0]  sel_be;
  logic        sel_we, sel_hit, strobe;
  logic        rsp_live;
  logic [31:0] rsp_data;

  // Arbitration and RAM request steering.
  // ready_q keeps grants off for the first cycle after reset release.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    can_grant     = 1'b0;
    force_m0      = 1'b0;
    m0_gnt        = 1'b0;
    m1_gnt        = 1'b0;
    any_gnt       = 1'b0;
    sel_addr      = '0;
    sel_be        = '0;
    sel_we        = 1'b0;
    sel_hit       = 1'b0;
    strobe        = 1'b0;
    o_ram_addr    = '0;
    o_ram_be      = '0;
    o_ram_wr_en   = 1'b0;
    o_ram_rd_en   = 1'b0;
    o_ram_wr_data = '0;

    can_grant = i_rst_n && ready_q && !i_ram_busy;
    force_m0  = i_m0_req && (wait_cnt_q == c_max_wait);
    m1_gnt    = can_grant && i_m1_req && !force_m0;
    m0_gnt    = can_grant && i_m0_req && !m1_gnt;
    any_gnt   = m0_gnt || m1_gnt;

    sel_addr = m1_gnt ? i_m1_addr : i_m0_addr;
    sel_be   = m1_gnt ? i_m1_be : 4'hf;
    sel_we   = m1_gnt && i_m1_we;
    sel_hit  = in_region(sel_addr);
    strobe   = any_gnt && sel_hit;

    if (strobe) begin
      o_ram_addr  = sel_addr;
      o_ram_be    = sel_be;
      o_ram_wr_en = sel_we;
      o_ram_rd_en = !sel_we;
      if (sel_we) o_ram_wr_data = i_m1_wdata;
    end
  end

  assign o_m0_gnt = m0_gnt;
  assign o_m1_gnt = m1_gnt;

  // Next-state: starvation counter and one-deep response tracker.
  always_comb begin
    wait_cnt_d  = '0;
    ready_d     = 1'b1;
    rsp_vld_d   = any_gnt;
    rsp_owner_d = m1_gnt;
    rsp_err_d   = any_gnt && !sel_hit;
    rsp_rd_d    = strobe && !sel_we;
    if (i_m0_req && !m0_gnt) begin
      wait_cnt_d = (wait_cnt_q == c_max_wait) ? wait_cnt_q : wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    if (!i_rst_n) begin
      wait_cnt_q  <= '0;
      ready_q     <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_owner_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      ready_q     <= ready_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rd_q    <= rsp_rd_d;
    end
  end

  // A response pending when reset hits is dropped in that same cycle.
  assign rsp_live = rsp_vld_q && i_rst_n;
  assign rsp_data = (rsp_live && rsp_rd_q) ? i_ram_rd_data : 32'h0;

  assign o_m0_rvalid = rsp_live && !rsp_owner_q;
  assign o_m0_err    = rsp_live && !rsp_owner_q && rsp_err_q;
  assign o_m0_rdata  = !rsp_owner_q ? rsp_data : 32'h0;

  assign o_m1_rvalid = rsp_live && rsp_owner_q;
  assign o_m1_err    = rsp_live && rsp_owner_q && rsp_err_q;
  assign o_m1_rdata  = rsp_owner_q ? rsp_data : 32'h0;

endmodule
